// File: rtl/uart_frame_parser_if.sv
// Byte-stream and command handshake bundle of the UART frame parser.
// master: parser side (drives rx_ready and the command); slave: FIFO/AXI side.
interface uart_frame_parser_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;

  modport master (
    input  rx_data, rx_valid, cmd_ready,
    output rx_ready, cmd_valid, cmd_write, cmd_addr, cmd_wdata
  );

  modport slave (
    output rx_data, rx_valid, cmd_ready,
    input  rx_ready, cmd_valid, cmd_write, cmd_addr, cmd_wdata
  );
endinterface

// File: rtl/uart_frame_parser.sv
// Assembles SOF/CMD/ADDR/DATA/CRC8 host frames into single read/write commands.
// Optional inter-byte timeout is built only when PARSER_TIMEOUT_EN is defined.
module uart_frame_parser #(
  parameter int unsigned TIMEOUT_CYCLES = 125000
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_frame_parser_if.master  bus,
  output logic                 err_valid,
  output logic [7:0]           err_code,
  output logic [7:0]           err_cmd,
  output logic [15:0]          drop_count
);

  localparam logic [7:0] SOF      = 8'hA5;
  localparam logic [7:0] CMD_RD   = 8'h10;
  localparam logic [7:0] CMD_WR   = 8'h20;
  localparam logic [7:0] ERR_CRC  = 8'h01;
  localparam logic [7:0] ERR_CMD  = 8'h02;
  localparam logic [7:0] ERR_TMO  = 8'h03;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 32'h00FF_FFFF) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must lie in 2..2^24-1");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DATA, S_CRC, S_OUT
  } state_t;

  state_t      state, state_nxt;
  logic        accept;
  logic        tmo_hit;
  logic        err_set;
  logic [7:0]  err_code_nxt;
  logic [7:0]  err_cmd_nxt;
  logic [7:0]  frame_cmd;
  logic [7:0]  crc_q;
  logic [1:0]  byte_cnt;
  logic        run_q;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  assign accept = bus.rx_valid & bus.rx_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    err_set      = 1'b0;
    err_code_nxt = 8'h00;
    err_cmd_nxt  = 8'h00;
    unique case (state)
      S_IDLE: if (accept && bus.rx_data == SOF) state_nxt = S_CMD;
      S_CMD: begin
        if (accept) begin
          if (bus.rx_data == CMD_RD || bus.rx_data == CMD_WR) begin
            state_nxt = S_ADDR;
          end else begin
            err_set      = 1'b1;
            err_code_nxt = ERR_CMD;
            err_cmd_nxt  = bus.rx_data;
            state_nxt    = S_IDLE;
          end
        end
      end
      S_ADDR: if (accept && byte_cnt == 2'd3) state_nxt = bus.cmd_write ? S_DATA : S_CRC;
      S_DATA: if (accept && byte_cnt == 2'd3) state_nxt = S_CRC;
      S_CRC: begin
        if (accept) begin
          if (bus.rx_data == crc_q) begin
            state_nxt = S_OUT;
          end else begin
            err_set      = 1'b1;
            err_code_nxt = ERR_CRC;
            err_cmd_nxt  = frame_cmd;
            state_nxt    = S_IDLE;
          end
        end
      end
      S_OUT: if (bus.cmd_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    // A timeout can only fire on a cycle with no accepted byte, so it never races the case above.
    if (tmo_hit) begin
      err_set      = 1'b1;
      err_code_nxt = ERR_TMO;
      err_cmd_nxt  = (state == S_CMD) ? 8'h00 : frame_cmd;
      state_nxt    = S_IDLE;
    end
  end

  always_comb begin
    bus.rx_ready  = run_q && (state != S_OUT);
    bus.cmd_valid = (state == S_OUT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q         <= 1'b0;
      err_valid     <= 1'b0;
      err_code      <= '0;
      err_cmd       <= '0;
      drop_count    <= '0;
      frame_cmd     <= '0;
      crc_q         <= '0;
      byte_cnt      <= '0;
      bus.cmd_write <= 1'b0;
      bus.cmd_addr  <= '0;
      bus.cmd_wdata <= '0;
    end else begin
      run_q     <= 1'b1;
      err_valid <= err_set;
      if (err_set) begin
        err_code <= err_code_nxt;
        err_cmd  <= err_cmd_nxt;
      end
      if (accept) begin
        unique case (state)
          S_IDLE: begin
            if (bus.rx_data == SOF) begin
              crc_q         <= '0;
              frame_cmd     <= '0;
              bus.cmd_write <= 1'b0;
              bus.cmd_addr  <= '0;
              bus.cmd_wdata <= '0;
            end else if (drop_count != 16'hFFFF) begin
              drop_count <= drop_count + 16'd1;
            end
          end
          S_CMD: begin
            frame_cmd     <= bus.rx_data;
            bus.cmd_write <= (bus.rx_data == CMD_WR);
            crc_q         <= crc8_step(crc_q, bus.rx_data);
            byte_cnt      <= '0;
          end
          S_ADDR: begin
            bus.cmd_addr[{byte_cnt, 3'b000} +: 8] <= bus.rx_data;
            crc_q    <= crc8_step(crc_q, bus.rx_data);
            byte_cnt <= byte_cnt + 2'd1;
          end
          S_DATA: begin
            bus.cmd_wdata[{byte_cnt, 3'b000} +: 8] <= bus.rx_data;
            crc_q    <= crc8_step(crc_q, bus.rx_data);
            byte_cnt <= byte_cnt + 2'd1;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef PARSER_TIMEOUT_EN
  localparam logic [23:0] TMO_LAST = 24'(TIMEOUT_CYCLES - 1);

  logic [23:0] tmo_cnt;
  logic        in_frame;

  assign in_frame = (state inside {S_CMD, S_ADDR, S_DATA, S_CRC});
  assign tmo_hit  = in_frame && !accept && (tmo_cnt == TMO_LAST);

  // Any state change (entry to CMD, leaving on error/OUT) restarts the idle count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                        tmo_cnt <= '0;
    else if (!in_frame || accept || state_nxt != state) tmo_cnt <= '0;
    else                                             tmo_cnt <= tmo_cnt + 24'd1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed self-checking bench for uart_frame_parser (read/write frames, CRC/CMD errors,
// backpressure, reset mid-frame, inter-byte timeout when PARSER_TIMEOUT_EN is defined).
module tb_uart_frame_parser;

`ifdef PARSER_TIMEOUT_EN
  localparam int unsigned TB_TIMEOUT = 100;
`else
  localparam int unsigned TB_TIMEOUT = 125000;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        err_valid;
  logic [7:0]  err_code;
  logic [7:0]  err_cmd;
  logic [15:0] drop_count;

  int checks = 0;
  int errors = 0;
  int err_pulses = 0;
  int overlap = 0;

  uart_frame_parser_if bus ();

  uart_frame_parser #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .err_valid  (err_valid),
    .err_code   (err_code),
    .err_cmd    (err_cmd),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (err_valid) err_pulses++;
    if (err_valid && bus.cmd_valid) overlap++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Bitwise reference: feedback = msb(crc) ^ data bit, shifted in MSB first.
  function automatic logic [7:0] model_crc(input logic [7:0] crc, input logic [7:0] d);
    logic [7:0] c;
    logic       fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[7] ^ d[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    while (!bus.rx_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) check("rx_ready_wait", 32'(bus.rx_ready), 32'd1);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] addr,
                            input logic [31:0] data, input logic corrupt);
    logic [7:0] body[$];
    logic [7:0] crc;
    body.push_back(cmd);
    for (int i = 0; i < 4; i++) body.push_back(addr[8*i +: 8]);
    if (cmd == 8'h20) for (int i = 0; i < 4; i++) body.push_back(data[8*i +: 8]);
    crc = 8'h00;
    foreach (body[i]) crc = model_crc(crc, body[i]);
    send_byte(8'hA5);
    foreach (body[i]) send_byte(body[i]);
    send_byte(corrupt ? (crc ^ 8'h01) : crc);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rx_ready"},   32'(bus.rx_ready),  32'd0);
    check({tag, "_cmd_valid"},  32'(bus.cmd_valid), 32'd0);
    check({tag, "_cmd_write"},  32'(bus.cmd_write), 32'd0);
    check({tag, "_cmd_addr"},   bus.cmd_addr,       32'h0);
    check({tag, "_cmd_wdata"},  bus.cmd_wdata,      32'h0);
    check({tag, "_err_valid"},  32'(err_valid),     32'd0);
    check({tag, "_err_code"},   32'(err_code),      32'h0);
    check({tag, "_err_cmd"},    32'(err_cmd),       32'h0);
    check({tag, "_drop_count"}, 32'(drop_count),    32'h0);
  endtask

  initial begin
    int pulses0;
    int n;
    bus.rx_valid  = 1'b0;
    bus.rx_data   = 8'h00;
    bus.cmd_ready = 1'b0;

    // Reset state
    tick(3);
    check_reset_values("rst");
    rst = 1'b1;
    tick(1);
    check("rx_ready_after_rst", 32'(bus.rx_ready), 32'd1);

    // Plain read frame with hand-computed CRC 0x32
    send_byte(8'hA5); send_byte(8'h10);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h32);
    check("rd_cmd_valid", 32'(bus.cmd_valid), 32'd1);
    check("rd_cmd_write", 32'(bus.cmd_write), 32'd0);
    check("rd_cmd_addr",  bus.cmd_addr,       32'h0);
    check("rd_cmd_wdata", bus.cmd_wdata,      32'h0);
    check("rd_rx_ready",  32'(bus.rx_ready),  32'd0);
    check("rd_no_err",    32'(err_pulses),    32'd0);
    bus.cmd_ready = 1'b1;
    tick(1);
    bus.cmd_ready = 1'b0;
    check("rd_handshake_done", 32'(bus.cmd_valid), 32'd0);
    check("rd_rx_ready_again", 32'(bus.rx_ready),  32'd1);

    // Bad CRC (0x33)
    send_byte(8'hA5); send_byte(8'h10);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h33);
    check("crc_err_valid", 32'(err_valid),     32'd1);
    check("crc_err_code",  32'(err_code),      32'h01);
    check("crc_err_cmd",   32'(err_cmd),       32'h10);
    check("crc_no_cmd",    32'(bus.cmd_valid), 32'd0);
    tick(1);
    check("crc_err_one_cycle", 32'(err_valid), 32'd0);
    check("crc_err_code_hold", 32'(err_code),  32'h01);
    check("crc_no_cmd_late",   32'(bus.cmd_valid), 32'd0);

    // Unsupported CMD, then stray bytes counted
    send_byte(8'hA5); send_byte(8'h30);
    check("cmd_err_valid", 32'(err_valid), 32'd1);
    check("cmd_err_code",  32'(err_code),  32'h02);
    check("cmd_err_cmd",   32'(err_cmd),   32'h30);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    check("drop_count_3", 32'(drop_count), 32'd3);

    // Next valid frame decodes normally after the errors
    bus.cmd_ready = 1'b1;
    send_frame(8'h10, 32'h0000_0044, 32'h0, 1'b0);
    check("after_err_cmd_valid", 32'(bus.cmd_valid), 32'd1);
    check("after_err_cmd_addr",  bus.cmd_addr,       32'h0000_0044);
    tick(1);
    check("b2b_cmd_valid_drop", 32'(bus.cmd_valid), 32'd0);
    check("b2b_rx_ready",       32'(bus.rx_ready),  32'd1);
    bus.cmd_ready = 1'b0;

    // Write frame held under backpressure, second frame queued behind it
    send_frame(8'h20, 32'h0000_1020, 32'hDEAD_BEEF, 1'b0);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hA5;
    for (int i = 0; i < 10; i++) begin
      check("wr_hold_valid",    32'(bus.cmd_valid), 32'd1);
      check("wr_hold_rx_ready", 32'(bus.rx_ready),  32'd0);
      tick(1);
    end
    check("wr_cmd_write", 32'(bus.cmd_write), 32'd1);
    check("wr_cmd_addr",  bus.cmd_addr,       32'h0000_1020);
    check("wr_cmd_wdata", bus.cmd_wdata,      32'hDEAD_BEEF);
    bus.cmd_ready = 1'b1;
    tick(1);
    bus.cmd_ready = 1'b0;
    check("wr_released", 32'(bus.cmd_valid), 32'd0);
    send_frame(8'h10, 32'h1234_5678, 32'h0, 1'b0);
    check("q2_cmd_valid", 32'(bus.cmd_valid), 32'd1);
    check("q2_cmd_write", 32'(bus.cmd_write), 32'd0);
    check("q2_cmd_addr",  bus.cmd_addr,       32'h1234_5678);
    check("q2_cmd_wdata", bus.cmd_wdata,      32'h0);
    check("drop_after_q2", 32'(drop_count),   32'd3);
    bus.cmd_ready = 1'b1;
    tick(1);
    bus.cmd_ready = 1'b0;

    // Inter-byte timeout
    pulses0 = err_pulses;
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h20);
`ifdef PARSER_TIMEOUT_EN
    n = 0;
    while (!err_valid && n < 300) begin
      tick(1);
      n++;
    end
    check("tmo_cycles",   32'(n),        32'd100);
    check("tmo_err_code", 32'(err_code), 32'h03);
    check("tmo_err_cmd",  32'(err_cmd),  32'h10);
    tick(1);
    check("tmo_one_cycle", 32'(err_valid), 32'd0);
    bus.cmd_ready = 1'b1;
    send_frame(8'h10, 32'h0000_0020, 32'h0, 1'b0);
    check("tmo_next_valid", 32'(bus.cmd_valid), 32'd1);
    check("tmo_next_addr",  bus.cmd_addr,       32'h0000_0020);
`else
    n = 0;
    tick(300);
    check("no_tmo_err", 32'(err_pulses - pulses0), 32'd0);
    bus.cmd_ready = 1'b1;
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(model_crc(model_crc(model_crc(model_crc(model_crc(8'h00, 8'h10), 8'h20),
                                                      8'h00), 8'h00), 8'h00));
    check("late_cmd_valid", 32'(bus.cmd_valid), 32'd1);
    check("late_cmd_addr",  bus.cmd_addr,       32'h0000_0020);
    check("late_no_err",    32'(err_pulses - pulses0), 32'd0);
`endif
    tick(1);
    bus.cmd_ready = 1'b0;

    // Reset in the middle of the address field
    pulses0 = err_pulses;
    send_byte(8'hA5); send_byte(8'h20); send_byte(8'h01); send_byte(8'h02);
    rst = 1'b0;
    #1;
    check_reset_values("midrst");
    tick(2);
    rst = 1'b1;
    tick(1);
    check("midrst_rx_ready", 32'(bus.rx_ready), 32'd1);
    check("midrst_no_err",   32'(err_pulses - pulses0), 32'd0);
    bus.cmd_ready = 1'b1;
    send_frame(8'h20, 32'hCAFE_F00C, 32'h0102_0304, 1'b0);
    check("midrst_cmd_valid", 32'(bus.cmd_valid), 32'd1);
    check("midrst_cmd_write", 32'(bus.cmd_write), 32'd1);
    check("midrst_cmd_addr",  bus.cmd_addr,       32'hCAFE_F00C);
    check("midrst_cmd_wdata", bus.cmd_wdata,      32'h0102_0304);
    tick(1);
    bus.cmd_ready = 1'b0;

    // A corrupted write frame: error carries CMD 0x20
    send_frame(8'h20, 32'h0000_0008, 32'h5555_AAAA, 1'b1);
    check("wr_crc_err_code", 32'(err_code), 32'h01);
    check("wr_crc_err_cmd",  32'(err_cmd),  32'h20);
    tick(2);

    check("err_cmd_overlap", 32'(overlap), 32'd0);
    check("drop_after_reset", 32'(drop_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
